fft_stage_sequencer: RTL
========================

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter N, 256, points per frame.
REQ-002 Parameter SIZE, 8, address width, log2(N).
REQ-003 Parameter NUM_STAGES, 4, butterfly stages per frame, range 1..8.
REQ-004 Parameter TIMEOUT, 1024, watchdog limit in cycles.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  single-cycle request to process one frame.
REQ-008 s_valid  in  1  input sample valid.
REQ-009 s_ready  out  1  sequencer accepts input sample.
REQ-010 ld_en  out  1  write strobe into bank 0.
REQ-011 ld_addr  out  SIZE  load address.
REQ-012 stage_start  out  1  one-cycle pulse launching a stage controller.
REQ-013 stage_idx  out  3  index of current stage.
REQ-014 stage_done  in  1  completion pulse from stage controller.
REQ-015 bank_sel  out  1  ping-pong bank read by current stage; stage writes ~bank_sel.
REQ-016 m_valid  out  1  result sample valid.
REQ-017 m_ready  in  1  downstream accepts result.
REQ-018 m_addr  out  SIZE  result read address in bank bank_sel.
REQ-019 m_last  out  1  high with final result beat (m_addr == N-1).
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 frame_cnt  out  8  completed frames, wraps 255->0.
REQ-022 timeout_err  out  1  sticky watchdog error flag.

Function
REQ-023 FSM states IDLE, LOAD, START, WAIT, UNLOAD; one-hot or binary encoding permitted, registered outputs only.
REQ-024 IDLE: start=1 -> LOAD; bank_sel, ld_addr, stage_idx cleared on entry to LOAD; start in any other state ignored.
REQ-025 LOAD: s_ready=1; on s_valid&s_ready, ld_en=1 and ld_addr = count, count increments; accepting beat N-1 -> START; s_valid low stalls without penalty.
REQ-026 ld_en and ld_addr are combinational from s_valid and registered count (same-cycle write), ld_en=0 outside LOAD.
REQ-027 START: stage_start=1 for exactly one cycle, then WAIT.
REQ-028 WAIT: stage_done=1 -> bank_sel toggles; if stage_idx==NUM_STAGES-1 -> UNLOAD with stage_idx held, else stage_idx+1 and -> START.
REQ-029 stage_done outside WAIT, and stage_done coincident with stage_start, are ignored.
REQ-030 Minimum gap stage_done to next stage_start: 1 cycle.
REQ-031 UNLOAD: m_valid=1; m_addr advances on m_valid&m_ready; m_ready low holds m_addr and m_valid; accepted beat N-1 -> IDLE, frame_cnt+1.
REQ-032 Result bank: bank_sel after NUM_STAGES toggles (bank 0 when NUM_STAGES even, bank 1 odd).
REQ-033 Latency start to first m_valid with s_valid and stage_done immediate: N + 2*NUM_STAGES + 1 cycles.
REQ-034 Counters are SIZE bits; wrap from N-1 never occurs since transition leaves state first.

Reset
REQ-035 rst_n low: state IDLE, s_ready=0, stage_start=0, stage_idx=0, bank_sel=0, m_valid=0, m_addr=0, m_last=0, busy=0, frame_cnt=0, timeout_err=0, ld_en=0, ld_addr=0.
REQ-036 Reset mid-operation abandons the frame; frame_cnt not incremented; first post-reset cycle behaves as IDLE.

Configuration
REQ-037 Macro FFT_STAGE_TIMEOUT_EN defined: cycle counter runs in WAIT, cleared on START; reaching TIMEOUT-1 without stage_done sets timeout_err=1 and forces IDLE next cycle; timeout_err clears only on reset or next accepted start.
REQ-038 Macro undefined: no watchdog counter, timeout_err constant 0, WAIT holds indefinitely.

Verification
REQ-039 Reset, start, 256 samples back-to-back, stage_done 5 cycles after each stage_start -> 4 stage_start pulses with stage_idx 0,1,2,3, bank_sel 0,1,0,1, UNLOAD from bank 0, m_last at m_addr 255, frame_cnt=1.
REQ-040 s_valid toggling every other cycle during LOAD -> ld_addr 0..255 contiguous, no gaps, START only after beat 255.
REQ-041 m_ready low for 3 cycles at m_addr 100 -> m_addr stays 100, m_valid stays 1, resumes 101.
REQ-042 stage_done pulsed in LOAD and start pulsed in WAIT -> no state change, stage_idx unaffected.
REQ-043 rst_n low during WAIT of stage 2 -> all outputs at reset values, frame_cnt unchanged, next start runs full frame.
REQ-044 With FFT_STAGE_TIMEOUT_EN, TIMEOUT=16, stage_done withheld -> timeout_err=1 sixteen cycles into WAIT, state IDLE; without macro, busy stays 1.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Frame sequencer for a ping-pong FFT: load N samples, run NUM_STAGES butterfly stages, then unload.
// Defining FFT_STAGE_TIMEOUT_EN adds a per-stage watchdog that aborts a stalled frame.
module fft_stage_sequencer #(
  parameter int N          = 256,
  parameter int SIZE       = 8,
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            ld_en,
  output logic [SIZE-1:0] ld_addr,
  output logic            stage_start,
  output logic [2:0]      stage_idx,
  input  logic            stage_done,
  output logic            bank_sel,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [SIZE-1:0] m_addr,
  output logic            m_last,
  output logic            busy,
  output logic [7:0]      frame_cnt,
  output logic            timeout_err
);

  localparam logic [SIZE-1:0] LAST_ADDR  = SIZE'(N - 1);
  localparam logic [SIZE-1:0] PRE_LAST   = SIZE'(N - 2);
  localparam logic [2:0]      LAST_STAGE = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_ld_cnt;
  logic [SIZE-1:0] r_m_addr;
  logic [2:0]      r_stage_idx;
  logic [7:0]      r_frame_cnt;
  logic            r_s_ready;
  logic            r_stage_start;
  logic            r_bank_sel;
  logic            r_m_valid;
  logic            r_m_last;
  logic            r_busy;

`ifdef FFT_STAGE_TIMEOUT_EN
  localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  // The load strobe is same-cycle with the sample so the bank write needs no extra pipeline stage.
  assign ld_en       = r_s_ready & s_valid;
  assign ld_addr     = r_ld_cnt;
  assign s_ready     = r_s_ready;
  assign stage_start = r_stage_start;
  assign stage_idx   = r_stage_idx;
  assign bank_sel    = r_bank_sel;
  assign m_valid     = r_m_valid;
  assign m_addr      = r_m_addr;
  assign m_last      = r_m_last;
  assign busy        = r_busy;
  assign frame_cnt   = r_frame_cnt;

  // Sequencer FSM with every output registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ld_cnt      <= {SIZE{1'b0}};
      r_m_addr      <= {SIZE{1'b0}};
      r_stage_idx   <= 3'd0;
      r_frame_cnt   <= 8'd0;
      r_s_ready     <= 1'b0;
      r_stage_start <= 1'b0;
      r_bank_sel    <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_busy        <= 1'b0;
`ifdef FFT_STAGE_TIMEOUT_EN
      r_wd_cnt      <= {WD_W{1'b0}};
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_stage_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_LOAD;
            r_s_ready   <= 1'b1;
            r_busy      <= 1'b1;
            r_ld_cnt    <= {SIZE{1'b0}};
            r_bank_sel  <= 1'b0;
            r_stage_idx <= 3'd0;
`ifdef FFT_STAGE_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            // The counter stops at N-1 rather than wrapping; the state change ends the load.
            if (r_ld_cnt == LAST_ADDR) begin
              r_state       <= ST_START;
              r_s_ready     <= 1'b0;
              r_stage_start <= 1'b1;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
            end
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
`ifdef FFT_STAGE_TIMEOUT_EN
          r_wd_cnt <= {WD_W{1'b0}};
`endif
        end
        ST_WAIT: begin
          if (stage_done) begin
            r_bank_sel <= ~r_bank_sel;
            if (r_stage_idx == LAST_STAGE) begin
              r_state   <= ST_UNLOAD;
              r_m_valid <= 1'b1;
              r_m_addr  <= {SIZE{1'b0}};
              r_m_last  <= (LAST_ADDR == {SIZE{1'b0}});
            end else begin
              r_state       <= ST_START;
              r_stage_idx   <= r_stage_idx + 3'd1;
              r_stage_start <= 1'b1;
            end
`ifdef FFT_STAGE_TIMEOUT_EN
          end else if (r_wd_cnt == WD_LAST) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
          end
        end
        ST_UNLOAD: begin
          if (m_ready) begin
            if (r_m_addr == LAST_ADDR) begin
              r_state     <= ST_IDLE;
              r_m_valid   <= 1'b0;
              r_m_last    <= 1'b0;
              r_m_addr    <= {SIZE{1'b0}};
              r_busy      <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
              r_m_addr <= r_m_addr + 1'b1;
              r_m_last <= (r_m_addr == PRE_LAST);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
